// File: rtl/regfile_wb_sequencer_if.sv
// Writeback request / register-file write-port bundle for regfile_wb_sequencer.
// The producer (memory stage side) uses the master modport; the sequencer uses slave.
interface regfile_wb_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 15
);
  // Writeback request from the memory stage
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] dstE;
  logic [DATA_W-1:0] valE;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valM;
  // Register-file write port and status
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  busy_mask;
  logic              idle;

  modport master (
    output wb_valid, dstE, valE, dstM, valM,
    input  wb_ready, wr_en, wr_addr, wr_data, busy_mask, idle
  );

  modport slave (
    input  wb_valid, dstE, valE, dstM, valM,
    output wb_ready, wr_en, wr_addr, wr_data, busy_mask, idle
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Serialises the E and M writes of each retired instruction onto the single
// register-file write port, always E first, and publishes a per-register busy
// mask so decode can stall on operands whose writes have not landed yet.
module regfile_wb_sequencer #(
  parameter int                DATA_W = 64,
  parameter int                ADDR_W = 4,
  parameter int                NREGS  = 15,
  parameter logic [ADDR_W-1:0] RNONE  = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_E = 2'd1,
    ST_WR_M = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]  LP_NREGS = (ADDR_W+1)'(NREGS);
  localparam logic [NREGS-1:0] LP_ONE   = NREGS'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_e_addr;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_pending;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [DATA_W-1:0] w_wr_data_nxt;
  logic [NREGS-1:0]  w_busy;
  logic              w_keep_e;
  logic              w_keep_m;
  logic              w_ready;
  logic              w_xfer;

  // A destination is real only if it is not the "none" code and names an architectural register.
  function automatic logic dst_ok(input logic [ADDR_W-1:0] dst);
    return (dst != RNONE) && ({1'b0, dst} < LP_NREGS);
  endfunction

  // M wins when both writes target the same register, so E is dropped in that case.
  assign w_keep_m = dst_ok(bus.dstM);
  assign w_keep_e = dst_ok(bus.dstE) && !(w_keep_m && (bus.dstE == bus.dstM));

  // Ready whenever this cycle is the last write of the current sequence (or nothing is pending).
  assign w_ready = (r_state == ST_IDLE) || (r_state == ST_WR_M) ||
                   ((r_state == ST_WR_E) && !r_m_pending);
  assign w_xfer  = bus.wb_valid && w_ready;

  // Next-state and next write-port values.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    w_state_nxt   = ST_IDLE;
    w_wr_addr_nxt = RNONE;
    w_wr_data_nxt = r_wr_data;
    if (w_xfer) begin
      if (w_keep_e) begin
        w_state_nxt   = ST_WR_E;
        w_wr_addr_nxt = bus.dstE;
        w_wr_data_nxt = bus.valE;
      end else if (w_keep_m) begin
        w_state_nxt   = ST_WR_M;
        w_wr_addr_nxt = bus.dstM;
        w_wr_data_nxt = bus.valM;
      end
    end else if ((r_state == ST_WR_E) && r_m_pending) begin
      w_state_nxt   = ST_WR_M;
      w_wr_addr_nxt = r_m_addr;
      w_wr_data_nxt = r_m_data;
    end
  end

  // State register and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= RNONE;
      r_wr_data <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state   <= w_state_nxt;
      r_wr_en   <= (w_state_nxt != ST_IDLE);
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  // Capture the request fields on every transfer; a reset discards whatever was captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_addr    <= RNONE;
      r_m_addr    <= RNONE;
      r_m_data    <= '0;
      r_m_pending <= 1'b0;
    end else if (w_xfer) begin
      r_e_addr    <= bus.dstE;
      r_m_addr    <= bus.dstM;
      r_m_data    <= bus.valM;
      r_m_pending <= w_keep_m;
    end
  end

  // Busy mask: every captured write not yet completed, including the one issuing now.
  always_comb begin
    w_busy = '0;
    case (r_state)
      ST_WR_E: begin
        w_busy = LP_ONE << r_e_addr;
        if (r_m_pending) w_busy = w_busy | (LP_ONE << r_m_addr);
      end
      ST_WR_M: w_busy = LP_ONE << r_m_addr;
      default: w_busy = '0;
    endcase
  end

  assign bus.wb_ready  = w_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy_mask = w_busy;
  assign bus.idle      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scoreboard bench for regfile_wb_sequencer: the model turns each accepted request
// into an ordered list of register writes; a negedge monitor compares the write port,
// busy mask, idle and ready against that list every cycle.
module tb_regfile_wb_sequencer;

  localparam int          NREGS = 15;
  localparam logic [3:0]  RNONE = 4'hF;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_sequencer_if bus ();

  regfile_wb_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  wr_t         exp_q[$];
  logic [63:0] last_data = '0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request becomes the list of writes it must produce, E before M,
  // with invalid destinations dropped and E dropped when both target the same register.
  always @(posedge clk) begin
    if (!rst && bus.wb_valid && bus.wb_ready) begin
      automatic logic e_ok = (bus.dstE < 4'(NREGS));
      automatic logic m_ok = (bus.dstM < 4'(NREGS));
      if (e_ok && !(m_ok && bus.dstE == bus.dstM)) exp_q.push_back('{bus.dstE, bus.valE});
      if (m_ok) exp_q.push_back('{bus.dstM, bus.valM});
    end
  end

  // Monitor: the head of the list is the write issuing this cycle; the rest are pending.
  always @(negedge clk) begin
    if (!rst) begin
      automatic logic [14:0] exp_busy = '0;
      foreach (exp_q[i]) exp_busy[exp_q[i].addr] = 1'b1;
      check("busy_mask", 64'(bus.busy_mask), 64'(exp_busy));
      check("idle", 64'(bus.idle), 64'(exp_q.size() == 0));
      check("wr_en", 64'(bus.wr_en), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("wr_addr", 64'(bus.wr_addr), 64'(exp_q[0].addr));
        check("wr_data", bus.wr_data, exp_q[0].data);
        last_data = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        check("idle_wr_addr", 64'(bus.wr_addr), 64'(RNONE));
        check("idle_wr_data", bus.wr_data, last_data);
      end
      check("wb_ready", 64'(bus.wb_ready), 64'(exp_q.size() == 0));
    end
  end

  // Present one request and hold it until accepted; returns at the negedge after the transfer.
  task automatic send(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
    int waited = 0;
    bus.dstE = de; bus.valE = ve; bus.dstM = dm; bus.valM = vm;
    bus.wb_valid = 1'b1;
    #1;
    while (!bus.wb_ready && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.wb_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: wb_ready stuck low for dstE=%0h dstM=%0h", de, dm);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bus.wb_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_checks();
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'(RNONE));
    check("rst_wr_data", bus.wr_data, 64'd0);
    check("rst_busy", 64'(bus.busy_mask), 64'd0);
    check("rst_idle", 64'(bus.idle), 64'd1);
    check("rst_ready", 64'(bus.wb_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wb_valid = 1'b0;
    bus.dstE = RNONE; bus.valE = '0; bus.dstM = RNONE; bus.valM = '0;
    repeat (2) @(negedge clk);
    #1 reset_checks();
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);

    // Single E write
    send(4'h3, 64'h55, RNONE, 64'h0);
    idle_cycles(2);
    // popq-style: E then M
    send(4'h4, 64'h108, 4'h0, 64'hAB);
    idle_cycles(3);
    // Same destination: only M lands
    send(4'h4, 64'h108, 4'h4, 64'h77);
    idle_cycles(2);
    // Back-to-back single writes with valid held
    send(4'h1, 64'h10, RNONE, 64'h0);
    send(4'h2, 64'h20, RNONE, 64'h0);
    send(4'h5, 64'h50, RNONE, 64'h0);
    idle_cycles(2);
    // No-op request
    send(RNONE, 64'h1, RNONE, 64'h2);
    idle_cycles(2);
    // M-only, then two-write sequence followed immediately by another
    send(RNONE, 64'h0, 4'h9, 64'h99);
    send(4'hA, 64'hA0, 4'hB, 64'hB0);
    send(4'hC, 64'hC0, 4'hE, 64'hE0);
    idle_cycles(4);

    // Reset during the E write of a two-write sequence: the M write must never issue.
    send(4'h4, 64'h108, 4'h0, 64'hAB);
    bus.wb_valid = 1'b0;
    #2 rst = 1'b1;
    #1 reset_checks();
    exp_q.delete();
    last_data = '0;
    @(negedge clk); #1 rst = 1'b0;
    idle_cycles(3);

    // Randomised traffic with random gaps
    for (int i = 0; i < 400; i++) begin
      logic [3:0] de, dm;
      de = 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 5) == 0) ? de : 4'($urandom_range(0, 15));
      send(de, {$urandom, $urandom}, dm, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(4);
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
